comm_link_sup: RTL and testbench

COMM_LINK_SUP -- requirements
Module: comm_link_sup

---
 rtl/comm_pkg.sv | 17 +
 rtl/comm_link_sup_rr_arb.sv | 27 ++
 rtl/comm_link_sup.sv | 161 ++++++++++++++++
 tb/tb_comm_link_sup.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/comm_pkg.sv
`default_nettype none
// ==== comm_pkg : shared defaults and FSM encoding for the link supervisor (rev 1.0) ====
package comm_pkg;
  localparam int DEF_CH_NUM    = 4;
  localparam int DEF_ERR_LIMIT = 2;
  localparam int DEF_OK_LIMIT  = 8;
  localparam int DEF_CHK_TO    = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GRANT  = 3'd1,
    ST_START  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_UPDATE = 3'd4
  } state_t;
endpackage
`default_nettype wire

// File: rtl/comm_link_sup_rr_arb.sv
`default_nettype none
// ==== rr_arb : round-robin pick of the first request after the last grant (rev 1.0) ====
module rr_arb #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [N-1:0] gnt
);
  logic [W-1:0] idx;
  logic         found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= N; i++) begin
      idx = W'((int'(last) + i) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/comm_link_sup.sv
`default_nettype none
// ==== comm_link_sup : shared frame-checker scheduler and per-channel fault supervisor (rev 1.0) ====
module comm_link_sup
  import comm_pkg::*;
#(
  parameter int CH_NUM    = DEF_CH_NUM,
  parameter int ERR_LIMIT = DEF_ERR_LIMIT,
  parameter int OK_LIMIT  = DEF_OK_LIMIT,
  parameter int CHK_TO    = DEF_CHK_TO,
  localparam int SEL_W    = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic              clk_20M,
  input  logic              reset_n,
  input  logic [CH_NUM-1:0] frame_vld,
  output logic [CH_NUM-1:0] frame_ack,
  output logic [SEL_W-1:0]  ch_sel,
  output logic              chk_start,
  input  logic              chk_done,
  input  logic              chk_err,
  input  logic [CH_NUM-1:0] optbrk,
  output logic [CH_NUM-1:0] ch_fault,
  output logic [SEL_W-1:0]  act_ch,
  output logic              link_ok,
  output logic              irq
);
  localparam int EW = $clog2(ERR_LIMIT + 1);
  localparam int OW = $clog2(OK_LIMIT + 1);
  localparam int TW = $clog2(CHK_TO + 1);
  localparam logic [EW-1:0]    ERR_MAX  = EW'(ERR_LIMIT);
  localparam logic [EW-1:0]    ERR_PRE  = EW'(ERR_LIMIT - 1);
  localparam logic [OW-1:0]    OK_PRE   = OW'(OK_LIMIT - 1);
  localparam logic [TW-1:0]    TO_LAST  = TW'(CHK_TO - 1);
  localparam logic [SEL_W-1:0] LAST_RST = SEL_W'(CH_NUM - 1);

  state_t            state, state_nx;
  logic [CH_NUM-1:0] req, gnt, fault_q;
  logic [SEL_W-1:0]  last, gnt_idx, act_nx;
  logic [TW-1:0]     timer;
  logic              res_err, timeout, upd;

  // Broken channels are masked here so their requests stay pending.
  assign req     = frame_vld & ~optbrk;
  assign timeout = (timer == TO_LAST);
  assign upd     = (state == ST_UPDATE);
  assign link_ok = ~&ch_fault;

  rr_arb #(.N(CH_NUM), .W(SEL_W)) u_rr_arb (
    .req  (req),
    .last (last),
    .gnt  (gnt)
  );

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < CH_NUM; i++)
      if (gnt[i]) gnt_idx = SEL_W'(i);
  end

  always_ff @(posedge clk_20M or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (|req) state_nx = ST_GRANT;
      ST_GRANT:  state_nx = ST_START;
      ST_START:  state_nx = ST_WAIT;
      ST_WAIT:   if (chk_done || timeout) state_nx = ST_UPDATE;
      ST_UPDATE: state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    frame_ack = '0;
    chk_start = 1'b0;
    if (state == ST_GRANT) frame_ack[ch_sel] = 1'b1;
    if (state == ST_START) chk_start = 1'b1;
  end

  always_ff @(posedge clk_20M or negedge reset_n) begin
    if (!reset_n) begin
      ch_sel  <= '0;
      last    <= LAST_RST;
      timer   <= '0;
      res_err <= 1'b0;
    end else begin
      if (state == ST_IDLE && |req) begin
        ch_sel <= gnt_idx;
        last   <= gnt_idx;
      end
      if (state == ST_WAIT) begin
        timer <= timer + TW'(1);
        if (chk_done)     res_err <= chk_err;
        else if (timeout) res_err <= 1'b1;
      end else begin
        timer <= '0;
      end
    end
  end

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    logic [EW-1:0] err_cnt;
    logic [OW-1:0] ok_cnt;
    logic          fault;
    logic          hit;

    assign hit         = upd && (ch_sel == SEL_W'(i));
    assign ch_fault[i] = fault;

    always_ff @(posedge clk_20M or negedge reset_n) begin
      if (!reset_n) begin
        err_cnt <= '0;
        ok_cnt  <= '0;
        fault   <= 1'b0;
      end else if (optbrk[i]) begin
        err_cnt <= '0;
        ok_cnt  <= '0;
        fault   <= 1'b1;
      end else if (hit) begin
        if (res_err) begin
          ok_cnt <= '0;
          if (err_cnt != ERR_MAX) err_cnt <= err_cnt + EW'(1);
          if (err_cnt >= ERR_PRE) fault <= 1'b1;
        end else begin
          err_cnt <= '0;
          if (fault) begin
            if (ok_cnt >= OK_PRE) begin
              fault  <= 1'b0;
              ok_cnt <= '0;
            end else begin
              ok_cnt <= ok_cnt + OW'(1);
            end
          end
        end
      end
    end
  end

  // Descending scan leaves the lowest fault-free index; all-faulted keeps the old one.
  always_comb begin
    act_nx = act_ch;
    for (int i = CH_NUM - 1; i >= 0; i--)
      if (!ch_fault[i]) act_nx = SEL_W'(i);
  end

  always_ff @(posedge clk_20M or negedge reset_n) begin
    if (!reset_n) begin
      act_ch  <= '0;
      fault_q <= '0;
      irq     <= 1'b0;
    end else begin
      act_ch  <= act_nx;
      fault_q <= ch_fault;
      irq     <= (ch_fault != fault_q);
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_comm_link_sup.sv
`default_nettype none
// ==== tb_comm_link_sup : randomized self-checking bench for comm_link_sup (rev 1.0) ====
module tb_comm_link_sup;
  localparam int CH        = 4;
  localparam int ERR_LIMIT = 2;
  localparam int OK_LIMIT  = 8;
  localparam int CHK_TO    = 32;

  logic          clk_20M = 1'b0;
  logic          reset_n = 1'b0;
  logic [CH-1:0] frame_vld = '0;
  logic [CH-1:0] frame_ack;
  logic [1:0]    ch_sel;
  logic          chk_start;
  logic          chk_done = 1'b0;
  logic          chk_err = 1'b0;
  logic [CH-1:0] optbrk = '0;
  logic [CH-1:0] ch_fault;
  logic [1:0]    act_ch;
  logic          link_ok;
  logic          irq;

  comm_link_sup #(
    .CH_NUM    (CH),
    .ERR_LIMIT (ERR_LIMIT),
    .OK_LIMIT  (OK_LIMIT),
    .CHK_TO    (CHK_TO)
  ) dut (
    .clk_20M   (clk_20M),
    .reset_n   (reset_n),
    .frame_vld (frame_vld),
    .frame_ack (frame_ack),
    .ch_sel    (ch_sel),
    .chk_start (chk_start),
    .chk_done  (chk_done),
    .chk_err   (chk_err),
    .optbrk    (optbrk),
    .ch_fault  (ch_fault),
    .act_ch    (act_ch),
    .link_ok   (link_ok),
    .irq       (irq)
  );

  always #25 clk_20M = ~clk_20M;

  int n_chk  = 0;
  int n_fail = 0;
  int irq_cnt = 0;

  // Reference model: per-channel counters and fault flags, updated per finished check.
  logic [CH-1:0] m_fault;
  int            m_ecnt [CH];
  int            m_ocnt [CH];
  int            m_last;
  int            m_act;
  int            m_irq = 0;

  always @(posedge clk_20M) begin
    #5;
    if (irq === 1'b1) irq_cnt <= irq_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_fault = '0;
    for (int i = 0; i < CH; i++) begin
      m_ecnt[i] = 0;
      m_ocnt[i] = 0;
    end
    m_last = CH - 1;
    m_act  = 0;
  endtask

  task automatic model_apply(input int ch, input bit err, input int brk_ch);
    logic [CH-1:0] old;
    old = m_fault;
    if (err) begin
      m_ocnt[ch] = 0;
      if (m_ecnt[ch] < ERR_LIMIT) m_ecnt[ch]++;
      if (m_ecnt[ch] >= ERR_LIMIT) m_fault[ch] = 1'b1;
    end else begin
      m_ecnt[ch] = 0;
      if (m_fault[ch]) begin
        m_ocnt[ch]++;
        if (m_ocnt[ch] >= OK_LIMIT) begin
          m_fault[ch] = 1'b0;
          m_ocnt[ch]  = 0;
        end
      end
    end
    if (brk_ch >= 0) begin
      m_fault[brk_ch] = 1'b1;
      m_ecnt[brk_ch]  = 0;
      m_ocnt[brk_ch]  = 0;
    end
    if (m_fault != old) m_irq++;
    for (int i = 0; i < CH; i++)
      if (!m_fault[i]) begin
        m_act = i;
        break;
      end
  endtask

  function automatic int model_next();
    for (int k = 1; k <= CH; k++) begin
      int c;
      c = (m_last + k) % CH;
      if (frame_vld[c] && !optbrk[c]) return c;
    end
    return -1;
  endfunction

  task automatic cmp_state();
    chk("ch_fault", ch_fault, m_fault);
    chk("act_ch", act_ch, m_act);
    chk("link_ok", link_ok, (m_fault != '1));
    chk("irq_cnt", irq_cnt, m_irq);
  endtask

  // One grant/check/update round; dly<0 withholds chk_done to force the timeout path.
  task automatic serve(input int ch, input bit err, input int dly, input bit keep, input int brk_ch);
    bit seen;
    int n;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (frame_ack != '0) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk_20M);
    end
    chk("ack_seen", seen, 1);
    if (!seen || ch < 0) return;
    chk("ack_onehot", frame_ack, 32'd1 << ch);
    chk("sel_grant", ch_sel, ch);
    if (!keep) frame_vld[ch] = 1'b0;
    m_last = ch;
    @(negedge clk_20M);
    chk("start_pulse", chk_start, 1);
    chk("ack_width", frame_ack, 0);
    if (dly >= 0) begin
      @(negedge clk_20M);
      chk("start_width", chk_start, 0);
      repeat (dly) @(negedge clk_20M);
      chk_done = 1'b1;
      chk_err  = err;
      @(negedge clk_20M);
      chk_done = 1'b0;
      chk_err  = 1'b0;
      if (brk_ch >= 0) optbrk[brk_ch] = 1'b1;
      chk("sel_update", ch_sel, ch);
      @(negedge clk_20M);
    end else begin
      n = 0;
      while (n < CHK_TO + 8 && !ch_fault[ch]) begin
        @(negedge clk_20M);
        n++;
      end
      chk("timeout_lat", n, CHK_TO + 2);
    end
    model_apply(ch, err || (dly < 0), brk_ch);
    @(negedge clk_20M);
    cmp_state();
  endtask

  task automatic burst(input logic [CH-1:0] mask, input int n, input bit err);
    int ch;
    frame_vld = mask;
    for (int i = 0; i < n; i++) begin
      ch = model_next();
      if (i == n - 1 && i > 0) frame_vld = '0;
      serve(ch, err, $urandom_range(0, 5), (i != n - 1), -1);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  acks;
    bit  seen;

    model_reset();
    repeat (2) @(negedge clk_20M);
    chk("rst_link_ok", link_ok, 1);
    chk("rst_fault", ch_fault, 0);
    chk("rst_ack", frame_ack, 0);
    chk("rst_start", chk_start, 0);
    chk("rst_irq", irq, 0);
    chk("rst_sel", ch_sel, 0);
    chk("rst_act", act_ch, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_20M);
    cmp_state();

    // Round-robin over four held requests.
    burst(4'b1111, 5, 1'b0);

    // ch1 faults after two errors and recovers after eight good frames.
    burst(4'b0010, 2, 1'b1);
    chk("ch1_fault", ch_fault, 4'b0010);
    chk("ch1_irq", irq_cnt, 1);
    burst(4'b0010, 8, 1'b0);
    chk("ch1_clear", ch_fault, 4'b0000);
    chk("ch1_irq2", irq_cnt, 2);

    // Timeout counts as an error; a late chk_done changes nothing.
    burst(4'b0100, 1, 1'b1);
    frame_vld = 4'b0100;
    serve(2, 1'b1, -1, 1'b0, -1);
    chk_done = 1'b1;
    @(negedge clk_20M);
    chk_done = 1'b0;
    repeat (3) @(negedge clk_20M);
    cmp_state();

    // optbrk[0] coincides with a good update of ch0.
    frame_vld = 4'b0001;
    serve(model_next(), 1'b0, $urandom_range(0, 5), 1'b0, 0);
    chk("brk_fault0", ch_fault[0], 1);
    chk("brk_act", act_ch, 1);
    frame_vld = 4'b0011;
    serve(model_next(), 1'b0, $urandom_range(0, 5), 1'b0, -1);
    acks = 0;
    repeat (40) begin
      @(negedge clk_20M);
      if (frame_ack != '0) acks++;
    end
    chk("brk_no_grant", acks, 0);
    optbrk = '0;
    serve(model_next(), 1'b1, $urandom_range(0, 5), 1'b0, -1);

    // Fault the remaining channels.
    burst(4'b1010, 4, 1'b1);
    chk("all_link", link_ok, 0);
    chk("all_act", act_ch, 3);

    // Reset in the middle of a WAIT.
    frame_vld = 4'b0100;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_20M);
      if (frame_ack != '0) begin
        seen = 1'b1;
        break;
      end
    end
    chk("rw_ack_seen", seen, 1);
    frame_vld = '0;
    repeat (3) @(negedge clk_20M);
    reset_n = 1'b0;
    #1;
    chk("rw_fault", ch_fault, 0);
    chk("rw_ack", frame_ack, 0);
    chk("rw_start", chk_start, 0);
    chk("rw_irq", irq, 0);
    chk("rw_sel", ch_sel, 0);
    chk("rw_act", act_ch, 0);
    chk("rw_link", link_ok, 1);
    repeat (2) @(negedge clk_20M);
    reset_n = 1'b1;
    chk_done = 1'b1;
    @(negedge clk_20M);
    chk_done = 1'b0;
    acks = 0;
    repeat (10) begin
      @(negedge clk_20M);
      if (frame_ack != '0 || chk_start) acks++;
    end
    chk("rw_quiet", acks, 0);
    model_reset();
    cmp_state();

    // Randomized traffic against the model.
    for (int it = 0; it < 40; it++) begin
      if (frame_vld == '0) frame_vld = 4'($urandom_range(1, 15));
      serve(model_next(), ($urandom_range(0, 9) < 4), $urandom_range(0, 8), 1'b0, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
